// File: rtl/sru_seq_pla_unit.sv
`default_nettype none
// ============================================================================
// Module      : sru_seq_pla_unit
// Description : Sequencer trigger unit. A small PLA selects SEGMENT_SIZE bits
//               of the trigger vector through per-input muxes and ORs a chosen
//               set of minterms (Match). A mode stage then qualifies that
//               result as LEVEL, STICKY, COUNT or EDGE (Select). The
//               configuration is loaded serially into a shadow register and
//               copied into the active register on commit.
// Ports       : clk         - clock, all state changes on the rising edge
//               rst_n       - synchronous active-low reset
//               Trigger     - [M-1:0] observed trigger vector
//               CfgShiftEn  - shift the shadow register by one bit
//               CfgShiftIn  - serial configuration data in
//               CfgShiftOut - shadow MSB, for daisy-chaining units
//               CfgCommit   - copy shadow into active config
//               Clear       - clear sticky flag, counter and edge history
//               Match       - registered raw PLA result
//               Select      - registered mode-qualified result
// Revision    : 1.0 - initial release
// ============================================================================
module sru_seq_pla_unit #(
    parameter int M            = 8,
    parameter int SEGMENT_SIZE = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] Trigger,
    input  logic         CfgShiftEn,
    input  logic         CfgShiftIn,
    output logic         CfgShiftOut,
    input  logic         CfgCommit,
    input  logic         Clear,
    output logic         Match,
    output logic         Select
);

    localparam int L      = $clog2(M);
    localparam int NUM_MT = 2 ** SEGMENT_SIZE;
    localparam int MUX_W  = SEGMENT_SIZE * L;
    localparam int CFG_W  = MUX_W + NUM_MT + 2 + CNT_WIDTH;

    localparam logic [1:0] c_mode_level  = 2'b00;
    localparam logic [1:0] c_mode_sticky = 2'b01;
    localparam logic [1:0] c_mode_count  = 2'b10;
    localparam logic [1:0] c_mode_edge   = 2'b11;

    logic [CFG_W-1:0]     r_shadow;
    logic [CFG_W-1:0]     r_active;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_match;
    logic                 r_match_d;
    logic                 r_select;

    // Active configuration fields, LSB first
    logic [MUX_W-1:0]     w_regmux;
    logic [NUM_MT-1:0]    w_orsel;
    logic [1:0]           w_mode;
    logic [CNT_WIDTH-1:0] w_thr;

    assign w_regmux = r_active[MUX_W-1:0];
    assign w_orsel  = r_active[MUX_W +: NUM_MT];
    assign w_mode   = r_active[MUX_W+NUM_MT +: 2];
    assign w_thr    = r_active[CFG_W-1 -: CNT_WIDTH];

    // Trigger padded to the full mux index range so that indices >= M read 0
    logic [(2**L)-1:0] w_trig_ext;

    always_comb begin
        w_trig_ext        = '0;
        w_trig_ext[M-1:0] = Trigger;
    end

    logic [SEGMENT_SIZE-1:0] w_sel;

    generate
        for (genvar i = 0; i < SEGMENT_SIZE; i++) begin : g_sel
            logic [L-1:0] w_idx;
            assign w_idx    = w_regmux[(i+1)*L-1 -: L];
            assign w_sel[i] = w_trig_ext[w_idx];
        end
    endgenerate

    // Minterm k: bit i of k chooses the true or complemented selected input
    logic [NUM_MT-1:0] w_mt;
    logic              w_raw;

    always_comb begin
        w_mt = '0;
        for (int k = 0; k < NUM_MT; k++) begin
            w_mt[k] = 1'b1;
            for (int i = 0; i < SEGMENT_SIZE; i++) begin
                if (((k >> i) & 1) == 1) begin
                    w_mt[k] = w_mt[k] & w_sel[i];
                end else begin
                    w_mt[k] = w_mt[k] & ~w_sel[i];
                end
            end
        end
    end

    assign w_raw = |(w_mt & w_orsel);

    // COUNT arithmetic is one bit wider so cnt+1 never overflows at all-ones
    logic [CNT_WIDTH:0]   w_thr_eff;
    logic [CNT_WIDTH:0]   w_cnt_inc;
    logic                 w_cnt_hit;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    assign w_thr_eff  = (w_thr == '0) ? {{CNT_WIDTH{1'b0}}, 1'b1} : {1'b0, w_thr};
    assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_cnt_hit  = (w_cnt_inc >= w_thr_eff);
    assign w_cnt_next = w_cnt_hit ? w_thr_eff[CNT_WIDTH-1:0] : w_cnt_inc[CNT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_cnt     <= '0;
            r_match   <= 1'b0;
            r_match_d <= 1'b0;
            r_select  <= 1'b0;
        end else begin
            if (CfgShiftEn) begin
                r_shadow <= {r_shadow[CFG_W-2:0], CfgShiftIn};
            end

            if (CfgCommit) begin
                // Commit takes the pre-shift shadow and restarts the qualifier
                r_active  <= r_shadow;
                r_cnt     <= '0;
                r_match   <= 1'b0;
                r_select  <= 1'b0;
                r_match_d <= r_match;
            end else begin
                r_match <= w_raw;
                if (Clear) begin
                    r_select  <= 1'b0;
                    r_cnt     <= '0;
                    r_match_d <= 1'b0;
                end else begin
                    r_match_d <= r_match;
                    case (w_mode)
                        c_mode_level: begin
                            r_select <= r_match;
                            r_cnt    <= '0;
                        end
                        c_mode_sticky: begin
                            r_select <= r_select | r_match;
                            r_cnt    <= '0;
                        end
                        c_mode_count: begin
                            r_select <= r_match & w_cnt_hit;
                            r_cnt    <= r_match ? w_cnt_next : '0;
                        end
                        c_mode_edge: begin
                            r_select <= r_match & ~r_match_d;
                            r_cnt    <= '0;
                        end
                        default: begin
                            r_select <= 1'b0;
                            r_cnt    <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign CfgShiftOut = r_shadow[CFG_W-1];
    assign Match       = r_match;
    assign Select      = r_select;

endmodule
`default_nettype wire

// File: tb/tb_sru_seq_pla_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sru_seq_pla_unit
// Description : Directed self-checking bench for sru_seq_pla_unit. A second
//               instance with M=6 exercises out-of-range mux indices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sru_seq_pla_unit;

    // Config words {Thr[7:0], Mode[1:0], ORSel[3:0], Mux1[2:0], Mux0[2:0]}
    localparam logic [19:0] c_and_level  = {8'd0, 2'b00, 4'b1000, 3'd5, 3'd2};
    localparam logic [19:0] c_and_sticky = {8'd0, 2'b01, 4'b1000, 3'd5, 3'd2};
    localparam logic [19:0] c_and_cnt3   = {8'd3, 2'b10, 4'b1000, 3'd5, 3'd2};
    localparam logic [19:0] c_and_cnt0   = {8'd0, 2'b10, 4'b1000, 3'd5, 3'd2};
    localparam logic [19:0] c_xor_edge   = {8'd0, 2'b11, 4'b0110, 3'd5, 3'd2};
    localparam logic [19:0] c_oor        = {8'd0, 2'b00, 4'b0100, 3'd2, 3'd7};

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic [7:0] r_trigger = '0;
    logic       r_shift_en = 1'b0;
    logic       r_shift_in = 1'b0;
    logic       r_commit = 1'b0;
    logic       r_clear = 1'b0;
    logic       w_shift_out, w_match, w_select;
    logic       w2_shift_out, w2_match, w2_select;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 r_clk = ~r_clk;

    sru_seq_pla_unit #(.M(8), .SEGMENT_SIZE(2), .CNT_WIDTH(8)) dut (
        .clk(r_clk), .rst_n(r_rst_n), .Trigger(r_trigger),
        .CfgShiftEn(r_shift_en), .CfgShiftIn(r_shift_in), .CfgShiftOut(w_shift_out),
        .CfgCommit(r_commit), .Clear(r_clear), .Match(w_match), .Select(w_select)
    );

    sru_seq_pla_unit #(.M(6), .SEGMENT_SIZE(2), .CNT_WIDTH(8)) dut6 (
        .clk(r_clk), .rst_n(r_rst_n), .Trigger(r_trigger[5:0]),
        .CfgShiftEn(r_shift_en), .CfgShiftIn(r_shift_in), .CfgShiftOut(w2_shift_out),
        .CfgCommit(r_commit), .Clear(r_clear), .Match(w2_match), .Select(w2_select)
    );

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic shift_word(input logic [19:0] w);
        for (int i = 19; i >= 0; i--) begin
            r_shift_en = 1'b1;
            r_shift_in = w[i];
            tick();
        end
        r_shift_en = 1'b0;
        r_shift_in = 1'b0;
    endtask

    task automatic load_cfg(input logic [19:0] w);
        r_trigger = '0;
        shift_word(w);
        r_commit = 1'b1;
        tick();
        r_commit = 1'b0;
    endtask

    task automatic test_reset();
        r_rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({w_match, w_select, w_shift_out} !== 3'b000) $display("FAIL reset_outputs: got %b expected 000", {w_match, w_select, w_shift_out});
        else n_pass++;
        n_checks++;
        if (dut.r_active !== 20'h0) $display("FAIL reset_active: got %h expected 00000", dut.r_active);
        else n_pass++;
        r_rst_n = 1'b1;
        r_trigger = 8'hFF;
        tick();
        tick();
        n_checks++;
        if ({w_match, w_select} !== 2'b00) $display("FAIL reset_no_match: got %b expected 00", {w_match, w_select});
        else n_pass++;
    endtask

    task automatic test_level();
        load_cfg(c_and_level);
        r_trigger = 8'h24;
        tick();
        n_checks++;
        if ({w_match, w_select} !== 2'b10) $display("FAIL level_n1: got %b expected 10", {w_match, w_select});
        else n_pass++;
        tick();
        n_checks++;
        if ({w_match, w_select} !== 2'b11) $display("FAIL level_n2: got %b expected 11", {w_match, w_select});
        else n_pass++;
        r_trigger = 8'h04;
        tick();
        n_checks++;
        if ({w_match, w_select} !== 2'b01) $display("FAIL level_fall1: got %b expected 01", {w_match, w_select});
        else n_pass++;
        tick();
        n_checks++;
        if ({w_match, w_select} !== 2'b00) $display("FAIL level_fall2: got %b expected 00", {w_match, w_select});
        else n_pass++;
    endtask

    task automatic test_sticky();
        load_cfg(c_and_sticky);
        r_trigger = 8'h24;
        tick();
        r_trigger = 8'h00;
        tick();
        n_checks++;
        if (w_select !== 1'b1) $display("FAIL sticky_set: got %b expected 1", w_select);
        else n_pass++;
        tick();
        tick();
        tick();
        n_checks++;
        if ({w_match, w_select} !== 2'b01) $display("FAIL sticky_hold: got %b expected 01", {w_match, w_select});
        else n_pass++;
        // Second pulse registers Match=1, then Clear on the edge that would set
        r_trigger = 8'h24;
        tick();
        r_trigger = 8'h00;
        r_clear = 1'b1;
        tick();
        r_clear = 1'b0;
        n_checks++;
        if ({w_match, w_select} !== 2'b00) $display("FAIL sticky_clear: got %b expected 00", {w_match, w_select});
        else n_pass++;
        tick();
        n_checks++;
        if (w_select !== 1'b0) $display("FAIL sticky_after_clear: got %b expected 0", w_select);
        else n_pass++;
    endtask

    task automatic test_count();
        logic [4:0] exp_sel;
        logic [4:0] got_sel;
        load_cfg(c_and_cnt3);
        r_trigger = 8'h24;
        tick();
        exp_sel = 5'b00111;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) r_trigger = 8'h00;
            tick();
            got_sel[4-i] = w_select;
        end
        n_checks++;
        if (got_sel !== exp_sel) $display("FAIL count_thr3_seq: got %b expected %b", got_sel, exp_sel);
        else n_pass++;
        n_checks++;
        if (dut.r_cnt !== 8'd3) $display("FAIL count_saturate: got %0d expected 3", dut.r_cnt);
        else n_pass++;
        tick();
        n_checks++;
        if ({w_select, dut.r_cnt} !== {1'b0, 8'd0}) $display("FAIL count_drop: got sel=%b cnt=%0d expected sel=0 cnt=0", w_select, dut.r_cnt);
        else n_pass++;
        load_cfg(c_and_cnt0);
        r_trigger = 8'h24;
        tick();
        tick();
        n_checks++;
        if ({w_select, dut.r_cnt} !== {1'b1, 8'd1}) $display("FAIL count_thr0: got sel=%b cnt=%0d expected sel=1 cnt=1", w_select, dut.r_cnt);
        else n_pass++;
    endtask

    task automatic test_edge();
        int pulses;
        int first;
        load_cfg(c_xor_edge);
        pulses = 0;
        first = -1;
        r_trigger = 8'h04;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) r_trigger = 8'h00;
            tick();
            if (w_select === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (pulses != 1 || first != 1) $display("FAIL edge_pulse: got %0d pulses at %0d expected 1 pulse at 1", pulses, first);
        else n_pass++;
    endtask

    task automatic test_shift_chain();
        logic [19:0] old_word;
        logic [19:0] got_out;
        int pulses;
        old_word = c_xor_edge;
        pulses = 0;
        r_trigger = 8'h04;
        for (int i = 19; i >= 0; i--) begin
            got_out[i] = w_shift_out;
            r_shift_en = 1'b1;
            r_shift_in = c_and_level[i];
            tick();
            if (w_select === 1'b1) pulses++;
        end
        r_shift_en = 1'b0;
        n_checks++;
        if (got_out !== old_word) $display("FAIL shift_out_chain: got %h expected %h", got_out, old_word);
        else n_pass++;
        n_checks++;
        if (w_match !== 1'b1 || pulses != 1) $display("FAIL shift_old_cfg: got match=%b pulses=%0d expected match=1 pulses=1", w_match, pulses);
        else n_pass++;
        r_commit = 1'b1;
        tick();
        r_commit = 1'b0;
        n_checks++;
        if ({w_match, w_select, dut.r_cnt} !== 10'b0 || dut.r_active !== c_and_level) $display("FAIL commit_clear: got m=%b s=%b cnt=%0d act=%h expected 0 0 0 %h", w_match, w_select, dut.r_cnt, dut.r_active, c_and_level);
        else n_pass++;
        tick();
        n_checks++;
        if (w_match !== 1'b0) $display("FAIL commit_new_nomatch: got %b expected 0", w_match);
        else n_pass++;
        r_trigger = 8'h24;
        tick();
        tick();
        n_checks++;
        if ({w_match, w_select} !== 2'b11) $display("FAIL commit_new_match: got %b expected 11", {w_match, w_select});
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        load_cfg(c_oor);
        r_trigger = 8'h04;
        tick();
        n_checks++;
        if ({w_match, w2_match} !== 2'b11) $display("FAIL oor_bit2: got %b expected 11", {w_match, w2_match});
        else n_pass++;
        // Bit 7 exists only for M=8; the M=6 instance must still read sel_0 as 0
        r_trigger = 8'h84;
        tick();
        n_checks++;
        if ({w_match, w2_match} !== 2'b01) $display("FAIL oor_bit7: got %b expected 01", {w_match, w2_match});
        else n_pass++;
    endtask

    task automatic test_reset_mid_sticky();
        load_cfg(c_and_sticky);
        r_trigger = 8'h24;
        tick();
        tick();
        n_checks++;
        if (w_select !== 1'b1) $display("FAIL rst_pre_sticky: got %b expected 1", w_select);
        else n_pass++;
        r_trigger = 8'h00;
        for (int i = 0; i < 7; i++) begin
            r_shift_en = 1'b1;
            r_shift_in = 1'b1;
            tick();
        end
        r_rst_n = 1'b0;
        r_commit = 1'b1;
        r_clear = 1'b1;
        tick();
        r_rst_n = 1'b1;
        r_commit = 1'b0;
        r_clear = 1'b0;
        r_shift_en = 1'b0;
        r_shift_in = 1'b0;
        n_checks++;
        if ({w_match, w_select, w_shift_out} !== 3'b000 || dut.r_active !== 20'h0 || dut.r_shadow !== 20'h0)
            $display("FAIL rst_mid_sticky: got m=%b s=%b act=%h sh=%h expected 0 0 00000 00000", w_match, w_select, dut.r_active, dut.r_shadow);
        else n_pass++;
        r_trigger = 8'h24;
        tick();
        tick();
        n_checks++;
        if ({w_match, w_select} !== 2'b00) $display("FAIL rst_after: got %b expected 00", {w_match, w_select});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_level();
        test_sticky();
        test_count();
        test_edge();
        test_shift_chain();
        test_out_of_range();
        test_reset_mid_sticky();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
